// File: rtl/axi_rd_arb_if.sv
// AXI4 read-address and read-data channel bundle shared by the arbiter and memory side.
//   master : arbiter view (drives AR channel, rready; receives arready and R channel)
//   slave  : memory/interconnect view (the reverse)
interface axi_rd_arb_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arb.sv
// Two-requester (icache/dcache) AXI read arbiter.
// Round-robin grants a single AR slot, issues the AR from registers, and routes R beats back
// to the owning requester by rid with zero latency. Each requester has at most one read
// outstanding.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   i_* / d_*            : icache / dcache request (req, addr, size, burst) and
//                          response (rd_rdy pulse, ret_valid, ret_last)
//   ret_data             : shared rdata passthrough
//   wr_busy              : write channel in flight, blocks new AR grants
//   rd_busy              : any AR pending or read outstanding
//   axi                  : AXI AR/R channels (master modport)
module axi_rd_arb #(
  parameter logic [7:0] I_AXI_LEN = 8'd7,
  parameter logic [7:0] D_AXI_LEN = 8'd3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_rd_req,
  input  logic [31:0]  i_rd_addr,
  input  logic [1:0]   i_rd_size,
  input  logic         i_burst,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  input  logic         d_rd_req,
  input  logic [31:0]  d_rd_addr,
  input  logic [1:0]   d_rd_size,
  input  logic         d_burst,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_busy,
  output logic         rd_busy,
  axi_rd_arb_if.master axi
);

  typedef enum logic [1:0] {StIdle, StAr, StData} state_e;

  localparam logic [3:0] IdIcache = 4'd0;
  localparam logic [3:0] IdDcache = 4'd1;

  state_e      i_state_q, d_state_q;
  logic        gnt_q;      // grant issued last cycle, AR registers load this cycle
  logic        gnt_dc_q;   // owner of that grant: 1 = dcache
  logic        last_dc_q;  // 1 = dcache granted most recently
  logic        arvalid_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;
  logic [1:0]  arburst_q;

  logic        i_cand, d_cand, grant, pick_dc, ar_fire, i_hit, d_hit;
  logic        sel_burst;
  logic [1:0]  sel_size;

  assign i_cand  = i_rd_req & (i_state_q == StIdle);
  assign d_cand  = d_rd_req & (d_state_q == StIdle);
  // gnt_q counts as a pending AR: the slot is taken even though arvalid is not yet up.
  assign grant   = ~arvalid_q & ~gnt_q & ~wr_busy & (i_cand | d_cand);
  // Favour the requester not granted last; a lone candidate always wins.
  assign pick_dc = d_cand & (~i_cand | ~last_dc_q);
  assign ar_fire = arvalid_q & axi.arready;

  assign sel_burst = gnt_dc_q ? d_burst : i_burst;
  assign sel_size  = gnt_dc_q ? d_rd_size : i_rd_size;

  // R beats only count for a requester actually waiting on data; strays are dropped.
  assign i_hit = axi.rvalid & (axi.rid == IdIcache) & (i_state_q == StData);
  assign d_hit = axi.rvalid & (axi.rid == IdDcache) & (d_state_q == StData);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_state_q <= StIdle;
      d_state_q <= StIdle;
      gnt_q     <= 1'b0;
      gnt_dc_q  <= 1'b0;
      last_dc_q <= 1'b0;
      arvalid_q <= 1'b0;
      arid_q    <= 4'd0;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
      arburst_q <= 2'd0;
    end else begin
      gnt_q <= grant;
      if (grant) begin
        gnt_dc_q  <= pick_dc;
        last_dc_q <= pick_dc;
      end

      if (gnt_q) begin
        arvalid_q <= 1'b1;
        arid_q    <= gnt_dc_q ? IdDcache : IdIcache;
        araddr_q  <= gnt_dc_q ? d_rd_addr : i_rd_addr;
        if (sel_burst) begin
          arlen_q   <= gnt_dc_q ? D_AXI_LEN : I_AXI_LEN;
          arsize_q  <= 3'b010;
          arburst_q <= 2'b01;
        end else begin
          arlen_q   <= 8'd0;
          arsize_q  <= {1'b0, sel_size};
          arburst_q <= 2'b00;
        end
      end else if (ar_fire) begin
        arvalid_q <= 1'b0;
      end

      case (i_state_q)
        StIdle:  if (grant && !pick_dc) i_state_q <= StAr;
        StAr:    if (ar_fire && arid_q == IdIcache) i_state_q <= StData;
        StData:  if (i_hit && axi.rlast) i_state_q <= StIdle;
        default: i_state_q <= StIdle;
      endcase

      case (d_state_q)
        StIdle:  if (grant && pick_dc) d_state_q <= StAr;
        StAr:    if (ar_fire && arid_q == IdDcache) d_state_q <= StData;
        StData:  if (d_hit && axi.rlast) d_state_q <= StIdle;
        default: d_state_q <= StIdle;
      endcase
    end
  end

  assign axi.arvalid = arvalid_q;
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.rready  = 1'b1;

  assign i_rd_rdy    = ar_fire & (arid_q == IdIcache);
  assign d_rd_rdy    = ar_fire & (arid_q == IdDcache);
  assign i_ret_valid = i_hit;
  assign i_ret_last  = i_hit & axi.rlast;
  assign d_ret_valid = d_hit;
  assign d_ret_last  = d_hit & axi.rlast;
  // Held at zero while in reset so every output reads 0 then.
  assign ret_data    = reset ? axi.rdata : 32'd0;

  assign rd_busy = arvalid_q | (i_state_q != StIdle) | (d_state_q != StIdle);

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed self-checking bench for axi_rd_arb. Inputs change on the falling clock edge and
// outputs are sampled there (or #1 later for combinational R routing).
module tb_axi_rd_arb;
  logic        clk, reset;
  logic        i_rd_req, d_rd_req, i_burst, d_burst;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic [1:0]  i_rd_size, d_rd_size;
  logic        i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last;
  logic [31:0] ret_data;
  logic        wr_busy, rd_busy;
  int          checks, failures;

  axi_rd_arb_if bus ();

  axi_rd_arb #(
    .I_AXI_LEN(8'd7),
    .D_AXI_LEN(8'd3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rd_req   (i_rd_req),
    .i_rd_addr  (i_rd_addr),
    .i_rd_size  (i_rd_size),
    .i_burst    (i_burst),
    .i_rd_rdy   (i_rd_rdy),
    .i_ret_valid(i_ret_valid),
    .i_ret_last (i_ret_last),
    .d_rd_req   (d_rd_req),
    .d_rd_addr  (d_rd_addr),
    .d_rd_size  (d_rd_size),
    .d_burst    (d_burst),
    .d_rd_rdy   (d_rd_rdy),
    .d_ret_valid(d_ret_valid),
    .d_ret_last (d_ret_last),
    .ret_data   (ret_data),
    .wr_busy    (wr_busy),
    .rd_busy    (rd_busy),
    .axi        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_rd_req = 0; i_rd_addr = 0; i_rd_size = 0; i_burst = 0;
    d_rd_req = 0; d_rd_addr = 0; d_rd_size = 0; d_burst = 0;
    wr_busy = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 32'hdead_beef; bus.rlast = 0; bus.rvalid = 0;
  endtask

  // Leaves the bench on a falling edge with one rising edge already seen out of reset.
  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] got;
    idle_inputs();
    reset = 1;
    #3 reset = 0;
    #1;  // still before the first rising edge
    got = {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst,
           bus.arlock, bus.arcache, bus.arprot, 6'd0};
    checks++;
    if (got !== 64'd0) begin
      failures++; $display("FAIL reset_ar got=%h exp=0", got);
    end
    got = {32'd0, ret_data};
    checks++;
    if (got !== 64'd0) begin
      failures++; $display("FAIL reset_ret_data got=%h exp=0", got);
    end
    checks++;
    if ({i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, rd_busy,
         bus.rready} !== 8'b0000_0001) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000001",
               {i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, rd_busy,
                bus.rready});
    end
  endtask

  task automatic test_icache_burst();
    logic [31:0] exp_data;
    do_reset();
    i_rd_req = 1; i_burst = 1; i_rd_addr = 32'h1fc0_0000; bus.arready = 1;
    @(negedge clk);  // cycle 1: granted, arvalid not yet up
    checks++;
    if ({bus.arvalid, rd_busy} !== 2'b01) begin
      failures++; $display("FAIL ic_cycle1 got=%b exp=01", {bus.arvalid, rd_busy});
    end
    @(negedge clk);  // cycle 2
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize} !==
        {1'b1, 4'd0, 32'h1fc0_0000, 8'd7, 2'b01, 3'b010}) begin
      failures++;
      $display("FAIL ic_ar got=%h exp=%h",
               {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize},
               {1'b1, 4'd0, 32'h1fc0_0000, 8'd7, 2'b01, 3'b010});
    end
    checks++;
    if ({i_rd_rdy, d_rd_rdy} !== 2'b10) begin
      failures++; $display("FAIL ic_rdy got=%b exp=10", {i_rd_rdy, d_rd_rdy});
    end
    i_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({bus.arvalid, i_rd_rdy, rd_busy} !== 3'b001) begin
      failures++; $display("FAIL ic_after_hs got=%b exp=001", {bus.arvalid, i_rd_rdy, rd_busy});
    end
    for (int k = 0; k < 8; k++) begin
      exp_data = 32'ha000_0000 + k;
      bus.rvalid = 1; bus.rid = 4'd0; bus.rlast = (k == 7); bus.rdata = exp_data;
      #1;
      checks++;
      if ({i_ret_valid, i_ret_last, d_ret_valid, ret_data} !==
          {1'b1, (k == 7), 1'b0, exp_data}) begin
        failures++;
        $display("FAIL ic_beat%0d got=%h exp=%h", k,
                 {i_ret_valid, i_ret_last, d_ret_valid, ret_data},
                 {1'b1, (k == 7), 1'b0, exp_data});
      end
      @(negedge clk);
    end
    bus.rvalid = 0; bus.rlast = 0;
    checks++;
    if (rd_busy !== 1'b0) begin
      failures++; $display("FAIL ic_done_busy got=%b exp=0", rd_busy);
    end
  endtask

  task automatic test_both_round_robin();
    int  rids  [14] = '{1, 0, 1, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0};
    bit  lasts [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    bit  i_act, d_act, exp_i, exp_d;
    do_reset();
    i_rd_req = 1; i_burst = 1; i_rd_addr = 32'h0000_1000;
    d_rd_req = 1; d_burst = 1; d_rd_addr = 32'h8000_0040;
    bus.arready = 1;
    @(negedge clk);
    checks++;
    if (bus.arvalid !== 1'b0) begin
      failures++; $display("FAIL rr_c1_arvalid got=%b exp=0", bus.arvalid);
    end
    @(negedge clk);
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
         i_rd_rdy, d_rd_rdy} !== {1'b1, 4'd1, 32'h8000_0040, 8'd3, 2'b01, 3'b010, 2'b01}) begin
      failures++;
      $display("FAIL rr_first_dc got=%h exp=%h",
               {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
                i_rd_rdy, d_rd_rdy},
               {1'b1, 4'd1, 32'h8000_0040, 8'd3, 2'b01, 3'b010, 2'b01});
    end
    d_rd_req = 0;
    for (int c = 3; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.arvalid !== 1'b0) begin
        failures++; $display("FAIL rr_c%0d_arvalid got=%b exp=0", c, bus.arvalid);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
         i_rd_rdy, d_rd_rdy} !== {1'b1, 4'd0, 32'h0000_1000, 8'd7, 2'b01, 3'b010, 2'b10}) begin
      failures++;
      $display("FAIL rr_second_ic got=%h exp=%h",
               {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
                i_rd_rdy, d_rd_rdy},
               {1'b1, 4'd0, 32'h0000_1000, 8'd7, 2'b01, 3'b010, 2'b10});
    end
    i_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({bus.arvalid, rd_busy} !== 2'b01) begin
      failures++; $display("FAIL rr_outstanding got=%b exp=01", {bus.arvalid, rd_busy});
    end
    i_act = 1; d_act = 1;
    for (int k = 0; k < 14; k++) begin
      bus.rvalid = 1; bus.rid = 4'(rids[k]); bus.rlast = lasts[k]; bus.rdata = 32'(k);
      exp_i = (rids[k] == 0) && i_act;
      exp_d = (rids[k] == 1) && d_act;
      #1;
      checks++;
      if ({i_ret_valid, d_ret_valid, i_ret_last, d_ret_last} !==
          {exp_i, exp_d, exp_i & lasts[k], exp_d & lasts[k]}) begin
        failures++;
        $display("FAIL rr_beat%0d got=%b exp=%b", k,
                 {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last},
                 {exp_i, exp_d, exp_i & lasts[k], exp_d & lasts[k]});
      end
      if (exp_i && lasts[k]) i_act = 0;
      if (exp_d && lasts[k]) d_act = 0;
      @(negedge clk);
    end
    bus.rvalid = 0; bus.rlast = 0;
    checks++;
    if (rd_busy !== 1'b0) begin
      failures++; $display("FAIL rr_done_busy got=%b exp=0", rd_busy);
    end
  endtask

  task automatic test_ar_stall();
    do_reset();
    d_rd_req = 1; d_burst = 1; d_rd_addr = 32'h0000_2000; bus.arready = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
           i_rd_rdy, d_rd_rdy} !== {1'b1, 4'd1, 32'h0000_2000, 8'd3, 2'b01, 3'b010, 2'b00}) begin
        failures++;
        $display("FAIL stall%0d got=%h exp=%h", k,
                 {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
                  i_rd_rdy, d_rd_rdy},
                 {1'b1, 4'd1, 32'h0000_2000, 8'd3, 2'b01, 3'b010, 2'b00});
      end
      if (k == 1) wr_busy = 1;  // must not withdraw the pending AR
      @(negedge clk);
    end
    bus.arready = 1;
    #1;
    checks++;
    if ({i_rd_rdy, d_rd_rdy} !== 2'b01) begin
      failures++; $display("FAIL stall_hs_rdy got=%b exp=01", {i_rd_rdy, d_rd_rdy});
    end
    d_rd_req = 0;
    @(negedge clk);
    checks++;
    if ({bus.arvalid, d_rd_rdy} !== 2'b00) begin
      failures++; $display("FAIL stall_post_hs got=%b exp=00", {bus.arvalid, d_rd_rdy});
    end
    wr_busy = 0;
  endtask

  task automatic test_wr_busy_uncached();
    do_reset();
    wr_busy = 1; d_rd_req = 1; d_burst = 0; d_rd_size = 2'd0; d_rd_addr = 32'h0000_3003;
    bus.arready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.arvalid, rd_busy} !== 2'b00) begin
        failures++; $display("FAIL wrb_block%0d got=%b exp=00", k, {bus.arvalid, rd_busy});
      end
    end
    wr_busy = 0;  // cycle N
    @(negedge clk);
    checks++;
    if (bus.arvalid !== 1'b0) begin
      failures++; $display("FAIL wrb_n1 got=%b exp=0", bus.arvalid);
    end
    @(negedge clk);
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
         d_rd_rdy} !== {1'b1, 4'd1, 32'h0000_3003, 8'd0, 2'b00, 3'b000, 1'b1}) begin
      failures++;
      $display("FAIL uc_ar got=%h exp=%h",
               {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
                d_rd_rdy},
               {1'b1, 4'd1, 32'h0000_3003, 8'd0, 2'b00, 3'b000, 1'b1});
    end
    d_rd_req = 0;
    @(negedge clk);
    bus.rvalid = 1; bus.rid = 4'd1; bus.rlast = 1; bus.rdata = 32'h0000_00ab;
    #1;
    checks++;
    if ({d_ret_valid, d_ret_last, i_ret_valid, ret_data} !== {3'b110, 32'h0000_00ab}) begin
      failures++;
      $display("FAIL uc_beat got=%h exp=%h", {d_ret_valid, d_ret_last, i_ret_valid, ret_data},
               {3'b110, 32'h0000_00ab});
    end
    @(negedge clk);
    bus.rvalid = 0; bus.rlast = 0;
    checks++;
    if (rd_busy !== 1'b0) begin
      failures++; $display("FAIL uc_idle got=%b exp=0", rd_busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    i_rd_req = 1; i_burst = 1; i_rd_addr = 32'h1fc0_0020; bus.arready = 1;
    repeat (2) @(negedge clk);
    i_rd_req = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.rvalid = 1; bus.rid = 4'd0; bus.rlast = 0; bus.rdata = 32'(k);
      #1;
      checks++;
      if (i_ret_valid !== 1'b1) begin
        failures++; $display("FAIL mid_beat%0d got=%b exp=1", k, i_ret_valid);
      end
      @(negedge clk);
    end
    bus.rdata = 32'h5555_aaaa;
    #2 reset = 0;
    #1;
    checks++;
    if ({i_ret_valid, i_ret_last, rd_busy, bus.arvalid, ret_data} !== 36'd0) begin
      failures++;
      $display("FAIL mid_async_clear got=%h exp=0",
               {i_ret_valid, i_ret_last, rd_busy, bus.arvalid, ret_data});
    end
    @(negedge clk);
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      bus.rvalid = 1; bus.rid = 4'd0; bus.rlast = (k == 4);
      #1;
      checks++;
      if ({i_ret_valid, i_ret_last, d_ret_valid} !== 3'b000) begin
        failures++;
        $display("FAIL stale_beat%0d got=%b exp=000", k, {i_ret_valid, i_ret_last, d_ret_valid});
      end
      @(negedge clk);
    end
    bus.rvalid = 0; bus.rlast = 0;
    i_rd_req = 1; i_burst = 0; i_rd_size = 2'b10; i_rd_addr = 32'h1fc0_0100;
    @(negedge clk);
    checks++;
    if (bus.arvalid !== 1'b0) begin
      failures++; $display("FAIL post_rst_c1 got=%b exp=0", bus.arvalid);
    end
    @(negedge clk);
    checks++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize,
         i_rd_rdy} !== {1'b1, 4'd0, 32'h1fc0_0100, 8'd0, 2'b00, 3'b010, 1'b1}) begin
      failures++;
      $display("FAIL post_rst_ar got=%h exp=%h",
               {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arburst, bus.arsize, i_rd_rdy},
               {1'b1, 4'd0, 32'h1fc0_0100, 8'd0, 2'b00, 3'b010, 1'b1});
    end
    i_rd_req = 0;
    @(negedge clk);
    bus.rvalid = 1; bus.rid = 4'd0; bus.rlast = 1;
    #1;
    checks++;
    if ({i_ret_valid, i_ret_last} !== 2'b11) begin
      failures++; $display("FAIL post_rst_beat got=%b exp=11", {i_ret_valid, i_ret_last});
    end
    @(negedge clk);
    bus.rvalid = 0; bus.rlast = 0;
    checks++;
    if (rd_busy !== 1'b0) begin
      failures++; $display("FAIL post_rst_idle got=%b exp=0", rd_busy);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_icache_burst();
    test_both_round_robin();
    test_ar_stall();
    test_wr_busy_uncached();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
